// File: rtl/avmm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avmm_arb_pkg
// Description : Shared types and default widths for the two-to-one Avalon-MM
//               burst arbiter (FSM state encoding, read-response tag).
// Revision    : 1.0 - initial release
// ============================================================================
package avmm_arb_pkg;

    localparam int c_ADDR_W     = 48;
    localparam int c_DATA_W     = 512;
    localparam int c_BURST_W    = 4;
    localparam int c_PEND_DEPTH = 16;

    // Arbiter command-side states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WBURST = 2'd2
    } arb_state_e;

    // One entry per outstanding read burst: who issued it and how many beats
    typedef struct packed {
        logic                 id;
        logic [c_BURST_W-1:0] burstcount;
    } arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/avmm_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avmm_arb_tag_fifo
// Description : Synchronous FIFO of read-response tags. Pointers carry an
//               extra wrap bit so full and empty are told apart directly.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_arb_tag_fifo
    import avmm_arb_pkg::*;
#(
    parameter int DEPTH = c_PEND_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  arb_tag_t i_push_tag,
    input  logic     i_pop,
    output arb_tag_t o_head_tag,
    output logic     o_full,
    output logic     o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    arb_tag_t        r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_push_ok;
    logic            w_pop_ok;

    // A push is refused while full, regardless of a same-cycle pop
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_head_tag = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avmm_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avmm_burst_arbiter
// Description : Two-to-one Avalon-MM burst arbiter. Grants whole bursts
//               round-robin onto the expanded master and steers in-order read
//               responses back to the issuer through a tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_burst_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int BURST_W    = c_BURST_W,
    parameter int PEND_DEPTH = c_PEND_DEPTH
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,

    input  logic [ADDR_W-1:0]     req0_address,
    input  logic                  req0_read,
    input  logic                  req0_write,
    input  logic [DATA_W-1:0]     req0_writedata,
    input  logic [DATA_W/8-1:0]   req0_byteenable,
    input  logic [BURST_W-1:0]    req0_burstcount,
    output logic                  req0_waitrequest,
    output logic [DATA_W-1:0]     req0_readdata,
    output logic                  req0_readdatavalid,

    input  logic [ADDR_W-1:0]     req1_address,
    input  logic                  req1_read,
    input  logic                  req1_write,
    input  logic [DATA_W-1:0]     req1_writedata,
    input  logic [DATA_W/8-1:0]   req1_byteenable,
    input  logic [BURST_W-1:0]    req1_burstcount,
    output logic                  req1_waitrequest,
    output logic [DATA_W-1:0]     req1_readdata,
    output logic                  req1_readdatavalid,

    output logic [ADDR_W-1:0]     expanded_master_address,
    output logic                  expanded_master_read,
    output logic                  expanded_master_write,
    output logic [DATA_W-1:0]     expanded_master_writedata,
    output logic [DATA_W/8-1:0]   expanded_master_byteenable,
    output logic [BURST_W-1:0]    expanded_master_burstcount,
    input  logic                  expanded_master_waitrequest,
    input  logic [DATA_W-1:0]     expanded_master_readdata,
    input  logic                  expanded_master_readdatavalid
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e             r_state,      w_state_nxt;
    logic                   r_grant_id,   w_grant_nxt;
    logic                   r_last_grant, w_last_nxt;
    logic [BURST_W-1:0]     r_beats_left, w_beats_nxt;
    logic [BURST_W-1:0]     r_rsp_cnt;
    logic [DATA_W-1:0]      r_req0_readdata;
    logic [DATA_W-1:0]      r_req1_readdata;
    logic                   r_req0_rdv;
    logic                   r_req1_rdv;

    // Granted-requester view
    logic [ADDR_W-1:0]      w_g_address;
    logic                   w_g_read;
    logic                   w_g_write;
    logic [DATA_W-1:0]      w_g_writedata;
    logic [DATA_W/8-1:0]    w_g_byteenable;
    logic [BURST_W-1:0]     w_g_burstcount;
    logic [BURST_W-1:0]     w_g_bc_eff;

    logic                   w_elig0;
    logic                   w_elig1;
    logic                   w_cmd_en;
    logic                   w_em_read;
    logic                   w_em_write;
    logic                   w_wait_g;

    // Tag FIFO
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    arb_tag_t               w_push_tag;
    arb_tag_t               w_head_tag;
    logic [BURST_W-1:0]     w_head_bc;
    logic                   w_rsp_take;
    logic                   w_rsp_last;

    assign w_elig0 = req0_read || req0_write;
    assign w_elig1 = req1_read || req1_write;

    // Select the command fields of whichever requester holds the grant
    always_comb begin
        w_g_address    = req0_address;
        w_g_read       = req0_read;
        w_g_write      = req0_write;
        w_g_writedata  = req0_writedata;
        w_g_byteenable = req0_byteenable;
        w_g_burstcount = req0_burstcount;
        if (r_grant_id) begin
            w_g_address    = req1_address;
            w_g_read       = req1_read;
            w_g_write      = req1_write;
            w_g_writedata  = req1_writedata;
            w_g_byteenable = req1_byteenable;
            w_g_burstcount = req1_burstcount;
        end
    end

    // A zero burstcount is illegal and is handled as a single beat
    assign w_g_bc_eff = (w_g_burstcount == '0) ? BURST_W'(1) : w_g_burstcount;

    // Next-state, grant bookkeeping and command strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_grant;
        w_beats_nxt = r_beats_left;
        w_cmd_en    = 1'b0;
        w_em_read   = 1'b0;
        w_em_write  = 1'b0;
        w_wait_g    = 1'b1;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    // On a tie the requester not served last wins
                    w_grant_nxt = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                w_cmd_en = 1'b1;
                if (w_g_read) begin
                    // With no tag slot left the read is held off entirely
                    if (!w_fifo_full) begin
                        w_em_read = 1'b1;
                        w_wait_g  = expanded_master_waitrequest;
                        if (!expanded_master_waitrequest) begin
                            w_push      = 1'b1;
                            w_last_nxt  = r_grant_id;
                            w_state_nxt = IDLE;
                        end
                    end
                end else if (w_g_write) begin
                    w_em_write = 1'b1;
                    w_wait_g   = expanded_master_waitrequest;
                    if (!expanded_master_waitrequest) begin
                        if (w_g_bc_eff == BURST_W'(1)) begin
                            w_last_nxt  = r_grant_id;
                            w_state_nxt = IDLE;
                        end else begin
                            w_beats_nxt = w_g_bc_eff - BURST_W'(1);
                            w_state_nxt = WBURST;
                        end
                    end
                end
            end
            WBURST: begin
                // A requester pausing its write just stalls; the grant stays
                w_cmd_en   = 1'b1;
                w_em_write = w_g_write;
                w_wait_g   = expanded_master_waitrequest;
                if (w_g_write && !expanded_master_waitrequest) begin
                    if (r_beats_left == BURST_W'(1)) begin
                        w_last_nxt  = r_grant_id;
                        w_state_nxt = IDLE;
                    end else begin
                        w_beats_nxt = r_beats_left - BURST_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command-side registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= IDLE;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

    assign expanded_master_address    = w_cmd_en ? w_g_address    : '0;
    assign expanded_master_writedata  = w_cmd_en ? w_g_writedata  : '0;
    assign expanded_master_byteenable = w_cmd_en ? w_g_byteenable : '0;
    assign expanded_master_burstcount = w_cmd_en ? w_g_bc_eff     : '0;
    assign expanded_master_read       = w_em_read;
    assign expanded_master_write      = w_em_write;

    assign req0_waitrequest = r_grant_id ? 1'b1 : w_wait_g;
    assign req1_waitrequest = r_grant_id ? w_wait_g : 1'b1;

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign w_push_tag.id         = r_grant_id;
    assign w_push_tag.burstcount = c_BURST_W'(w_g_bc_eff);
    assign w_head_bc             = BURST_W'(w_head_tag.burstcount);

    // Beats arriving with nothing outstanding are discarded
    assign w_rsp_take = expanded_master_readdatavalid && !w_fifo_empty;
    assign w_rsp_last = (r_rsp_cnt + BURST_W'(1)) == w_head_bc;
    assign w_pop      = w_rsp_take && w_rsp_last;

    avmm_arb_tag_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_tag_fifo (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .i_push     (w_push),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_head_tag (w_head_tag),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // Register each response beat toward the head tag's owner
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rsp_cnt       <= '0;
            r_req0_rdv      <= 1'b0;
            r_req1_rdv      <= 1'b0;
            r_req0_readdata <= '0;
            r_req1_readdata <= '0;
        end else begin
            r_req0_rdv <= 1'b0;
            r_req1_rdv <= 1'b0;
            if (w_rsp_take) begin
                if (w_head_tag.id) begin
                    r_req1_rdv      <= 1'b1;
                    r_req1_readdata <= expanded_master_readdata;
                end else begin
                    r_req0_rdv      <= 1'b1;
                    r_req0_readdata <= expanded_master_readdata;
                end
                r_rsp_cnt <= w_rsp_last ? '0 : (r_rsp_cnt + BURST_W'(1));
            end
        end
    end

    assign req0_readdata      = r_req0_readdata;
    assign req1_readdata      = r_req1_readdata;
    assign req0_readdatavalid = r_req0_rdv;
    assign req1_readdatavalid = r_req1_rdv;

endmodule
`default_nettype wire

// File: tb/tb_avmm_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avmm_burst_arbiter
// Description : Directed self-checking bench for avmm_burst_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_burst_arbiter;

    localparam int c_AW = 48;
    localparam int c_DW = 512;
    localparam int c_BW = 4;

    logic               clk_clk = 1'b0;
    logic               reset_reset;
    logic [c_AW-1:0]    req0_address,   req1_address;
    logic               req0_read,      req1_read;
    logic               req0_write,     req1_write;
    logic [c_DW-1:0]    req0_writedata, req1_writedata;
    logic [c_DW/8-1:0]  req0_byteenable, req1_byteenable;
    logic [c_BW-1:0]    req0_burstcount, req1_burstcount;
    logic               req0_waitrequest, req1_waitrequest;
    logic [c_DW-1:0]    req0_readdata,  req1_readdata;
    logic               req0_readdatavalid, req1_readdatavalid;
    logic [c_AW-1:0]    em_address;
    logic               em_read, em_write;
    logic [c_DW-1:0]    em_writedata;
    logic [c_DW/8-1:0]  em_byteenable;
    logic [c_BW-1:0]    em_burstcount;
    logic               em_waitrequest;
    logic [c_DW-1:0]    em_readdata;
    logic               em_readdatavalid;

    int n_checks = 0;
    int n_errors = 0;
    int wbeats   = 0;

    always #5 clk_clk = ~clk_clk;

    avmm_burst_arbiter dut (
        .clk_clk                       (clk_clk),
        .reset_reset                   (reset_reset),
        .req0_address                  (req0_address),
        .req0_read                     (req0_read),
        .req0_write                    (req0_write),
        .req0_writedata                (req0_writedata),
        .req0_byteenable               (req0_byteenable),
        .req0_burstcount               (req0_burstcount),
        .req0_waitrequest              (req0_waitrequest),
        .req0_readdata                 (req0_readdata),
        .req0_readdatavalid            (req0_readdatavalid),
        .req1_address                  (req1_address),
        .req1_read                     (req1_read),
        .req1_write                    (req1_write),
        .req1_writedata                (req1_writedata),
        .req1_byteenable               (req1_byteenable),
        .req1_burstcount               (req1_burstcount),
        .req1_waitrequest              (req1_waitrequest),
        .req1_readdata                 (req1_readdata),
        .req1_readdatavalid            (req1_readdatavalid),
        .expanded_master_address       (em_address),
        .expanded_master_read          (em_read),
        .expanded_master_write         (em_write),
        .expanded_master_writedata     (em_writedata),
        .expanded_master_byteenable    (em_byteenable),
        .expanded_master_burstcount    (em_burstcount),
        .expanded_master_waitrequest   (em_waitrequest),
        .expanded_master_readdata      (em_readdata),
        .expanded_master_readdatavalid (em_readdatavalid)
    );

    // Count write beats actually accepted downstream
    always @(posedge clk_clk) begin
        if (!reset_reset && em_write && !em_waitrequest) begin
            wbeats <= wbeats + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_read(input int id, input logic v, input logic [c_AW-1:0] addr,
                            input logic [c_BW-1:0] bc);
        if (id == 0) begin
            req0_read = v; req0_address = addr; req0_burstcount = bc;
        end else begin
            req1_read = v; req1_address = addr; req1_burstcount = bc;
        end
    endtask

    // Returns at the negedge of the accepting cycle; n = cycles stalled first
    task automatic wait_accept(input int id, output int n);
        logic wr;
        n = 0;
        forever begin
            @(negedge clk_clk);
            wr = (id == 0) ? req0_waitrequest : req1_waitrequest;
            if (!wr) return;
            n++;
            if (n > 40) begin
                check_eq("accept_timeout", 64'(wr), 64'd0);
                return;
            end
        end
    endtask

    task automatic issue_read(input int id, input logic [c_AW-1:0] addr, input logic [c_BW-1:0] bc);
        int n;
        set_read(id, 1'b1, addr, bc);
        wait_accept(id, n);
        step();
        set_read(id, 1'b0, addr, bc);
    endtask

    // One downstream beat; exp_id 2 means the beat must be dropped
    task automatic rsp_beat(input logic [63:0] d, input int exp_id);
        em_readdatavalid = 1'b1;
        em_readdata      = {8{d}};
        step();
        em_readdatavalid = 1'b0;
        check_eq("rsp_rdv0", 64'(req0_readdatavalid), 64'(exp_id == 0));
        check_eq("rsp_rdv1", 64'(req1_readdatavalid), 64'(exp_id == 1));
        if (exp_id == 0) check_eq("rsp_data0", req0_readdata[63:0], d);
        if (exp_id == 1) check_eq("rsp_data1", req1_readdata[63:0], d);
    endtask

    initial begin
        int n;
        int w0;
        int ids [6];
        reset_reset = 1'b1;
        req0_address = '0; req0_read = 0; req0_write = 0; req0_writedata = '0;
        req0_byteenable = '1; req0_burstcount = 1;
        req1_address = '0; req1_read = 0; req1_write = 0; req1_writedata = '0;
        req1_byteenable = '1; req1_burstcount = 1;
        em_waitrequest = 0; em_readdata = '0; em_readdatavalid = 0;

        // Reset values
        repeat (3) step();
        check_eq("rst_wait0", 64'(req0_waitrequest), 64'd1);
        check_eq("rst_wait1", 64'(req1_waitrequest), 64'd1);
        check_eq("rst_em_read", 64'(em_read), 64'd0);
        check_eq("rst_em_write", 64'(em_write), 64'd0);
        check_eq("rst_em_addr", em_address, 64'd0);
        check_eq("rst_rdv0", 64'(req0_readdatavalid), 64'd0);
        check_eq("rst_rdata0", req0_readdata[63:0], 64'd0);
        reset_reset = 1'b0;

        // Simultaneous single reads: req0 first, one-cycle bubble, then req1
        set_read(0, 1'b1, 48'h0000_0000_0A00, 4'd1);
        set_read(1, 1'b1, 48'h0000_0000_0B00, 4'd1);
        wait_accept(0, n);
        check_eq("t1_n0", 64'(n), 64'd1);
        check_eq("t1_addr0", em_address, 64'h0A00);
        check_eq("t1_rd0", 64'(em_read), 64'd1);
        check_eq("t1_wait1", 64'(req1_waitrequest), 64'd1);
        step();
        req0_read = 1'b0;
        wait_accept(1, n);
        check_eq("t1_n1", 64'(n), 64'd1);
        check_eq("t1_addr1", em_address, 64'h0B00);
        step();
        req1_read = 1'b0;
        em_readdatavalid = 1'b1;
        em_readdata      = {8{64'hD0D0_0000_0000_0001}};
        @(negedge clk_clk);
        check_eq("t1_latency", 64'(req0_readdatavalid), 64'd0);
        step();
        em_readdatavalid = 1'b0;
        check_eq("t1_rdv0", 64'(req0_readdatavalid), 64'd1);
        check_eq("t1_rdv1", 64'(req1_readdatavalid), 64'd0);
        check_eq("t1_data0", req0_readdata[63:0], 64'hD0D0_0000_0000_0001);
        rsp_beat(64'hD1D1_0000_0000_0002, 1);

        // Write burst of 4 with downstream stalls; req1 read waits it out
        req0_write = 1'b1; req0_burstcount = 4'd4; req0_writedata = {8{64'h57}};
        set_read(1, 1'b1, 48'h0000_0000_0C00, 4'd1);
        w0 = wbeats;
        wait_accept(0, n);
        check_eq("t2_n0", 64'(n), 64'd1);
        check_eq("t2_em_write", 64'(em_write), 64'd1);
        check_eq("t2_em_bc", 64'(em_burstcount), 64'd4);
        check_eq("t2_wait1_b1", 64'(req1_waitrequest), 64'd1);
        step();
        for (int b = 2; b <= 4; b++) begin
            req0_writedata = {8{64'(32'h5700 + b)}};
            if (b == 2 || b == 3) begin
                em_waitrequest = 1'b1;
                @(negedge clk_clk);
                check_eq("t2_stall_wait0", 64'(req0_waitrequest), 64'd1);
                check_eq("t2_stall_wait1", 64'(req1_waitrequest), 64'd1);
                step();
                em_waitrequest = 1'b0;
            end
            if (b == 3) begin
                req0_write = 1'b0;
                @(negedge clk_clk);
                check_eq("t2_pause_write", 64'(em_write), 64'd0);
                check_eq("t2_pause_wait1", 64'(req1_waitrequest), 64'd1);
                step();
                req0_write = 1'b1;
            end
            @(negedge clk_clk);
            check_eq("t2_beat_wait0", 64'(req0_waitrequest), 64'd0);
            check_eq("t2_beat_wait1", 64'(req1_waitrequest), 64'd1);
            check_eq("t2_beat_data", em_writedata[63:0], 64'(32'h5700 + b));
            step();
        end
        req0_write = 1'b0;
        check_eq("t2_beats", 64'(wbeats - w0), 64'd4);
        wait_accept(1, n);
        check_eq("t2_n1", 64'(n), 64'd1);
        check_eq("t2_addr1", em_address, 64'h0C00);
        step();
        req1_read = 1'b0;
        rsp_beat(64'hC0C0, 1);

        // Fill all 16 tag slots, then a 17th read must be held off
        for (int i = 0; i < 16; i++) issue_read(0, 48'(i * 64), 4'd2);
        set_read(0, 1'b1, 48'h0000_0000_1000, 4'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_clk);
            check_eq("t3_full_read", 64'(em_read), 64'd0);
            check_eq("t3_full_wait", 64'(req0_waitrequest), 64'd1);
        end
        step();
        rsp_beat(64'h3000, 0);
        em_readdatavalid = 1'b1;
        em_readdata      = {8{64'h3001}};
        @(negedge clk_clk);
        check_eq("t3_popcyc_read", 64'(em_read), 64'd0);
        check_eq("t3_popcyc_wait", 64'(req0_waitrequest), 64'd1);
        step();
        em_readdatavalid = 1'b0;
        check_eq("t3_pop_rdv0", 64'(req0_readdatavalid), 64'd1);
        wait_accept(0, n);
        check_eq("t3_n17", 64'(n), 64'd0);
        check_eq("t3_addr17", em_address, 64'h1000);
        step();
        req0_read = 1'b0;
        for (int i = 0; i < 32; i++) rsp_beat(64'(32'h3100 + i), 0);
        rsp_beat(64'h3FFF, 2);

        // Interleaved bursts: responses split 3/1/2 to req0/req1/req0
        issue_read(0, 48'h2000, 4'd3);
        issue_read(1, 48'h2100, 4'd1);
        issue_read(0, 48'h2200, 4'd2);
        ids = '{0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) rsp_beat(64'(32'h4400 + i), ids[i]);

        // Reset during a write burst with two reads outstanding
        issue_read(0, 48'h5000, 4'd1);
        issue_read(1, 48'h5100, 4'd1);
        req1_write = 1'b1; req1_burstcount = 4'd4;
        wait_accept(1, n);
        step();
        @(negedge clk_clk);
        check_eq("t5_wburst_wait1", 64'(req1_waitrequest), 64'd0);
        step();
        reset_reset = 1'b1;
        step();
        check_eq("t5_rst_write", 64'(em_write), 64'd0);
        check_eq("t5_rst_wait0", 64'(req0_waitrequest), 64'd1);
        check_eq("t5_rst_wait1", 64'(req1_waitrequest), 64'd1);
        check_eq("t5_rst_bc", 64'(em_burstcount), 64'd0);
        check_eq("t5_rst_rdata1", req1_readdata[63:0], 64'd0);
        reset_reset = 1'b0;
        req1_write  = 1'b0;
        rsp_beat(64'h5555, 2);
        rsp_beat(64'h5556, 2);
        set_read(0, 1'b1, 48'h6000, 4'd1);
        set_read(1, 1'b1, 48'h6100, 4'd1);
        wait_accept(0, n);
        check_eq("t5_post_n0", 64'(n), 64'd1);
        check_eq("t5_post_addr0", em_address, 64'h6000);
        step();
        req0_read = 1'b0;
        wait_accept(1, n);
        step();
        req1_read = 1'b0;
        rsp_beat(64'h6600, 0);
        rsp_beat(64'h6601, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avmm_burst_arbiter.md
# avmm_burst_arbiter

Two-to-one Avalon-MM burst arbiter that shares the ASE expanded master (48-bit address, 512-bit data, 4-bit burstcount) between two kernel-side requesters. It grants whole bursts round-robin, muxes the granted command onto the expanded master and routes in-order read responses back to the issuing requester through a tag FIFO. It sits between the kernel memory interconnect and the `ase` expanded_master port.

## Interface
- ADDR_W, 48, address width
- DATA_W, 512, data width; byteenable is DATA_W/8
- BURST_W, 4, burstcount width; maximum burst is 2^(BURST_W-1) = 8
- PEND_DEPTH, 16, outstanding read bursts tracked; power of two
- clk_clk  in  1  single clock
- reset_reset  in  1  reset, synchronous, active-high
- reqN_address  in  ADDR_W  requester N (N=0,1) address
- reqN_read / reqN_write  in  1  command strobes; never both high
- reqN_writedata  in  DATA_W  write beat
- reqN_byteenable  in  DATA_W/8  byte lanes
- reqN_burstcount  in  BURST_W  beats in burst
- reqN_waitrequest  out  1  stall to requester N
- reqN_readdata  out  DATA_W  read beat to requester N
- reqN_readdatavalid  out  1  read beat valid to requester N
- expanded_master_address / _read / _write / _writedata / _byteenable / _burstcount  out  as req  granted command
- expanded_master_waitrequest  in  1  downstream stall
- expanded_master_readdata  in  DATA_W  downstream read beat
- expanded_master_readdatavalid  in  1  downstream read beat valid

## Operation
- FSM states: IDLE, GRANT, WBURST.
- IDLE: a requester is eligible when read or write is high; pick by round-robin (last_grant pointer; other requester wins a tie). Register grant id, go to GRANT. No eligible requester: stay.
- GRANT: drive expanded_master_* from the granted requester; reqG_waitrequest = expanded_master_waitrequest; non-granted waitrequest = 1.
- Read in GRANT with tag FIFO full: expanded_master_read = 0, reqG_waitrequest = 1 until space appears.
- Read accepted (read & !waitrequest): push {id, burstcount} to tag FIFO, update last_grant, go to IDLE.
- Write accepted: burstcount 1 → IDLE; else load beats_left = burstcount-1 → WBURST.
- WBURST: forward granted requester's write beats; each accepted beat decrements beats_left; on the accepted beat at beats_left == 1 → IDLE, update last_grant. Requester deasserting write mid-burst only stalls; the grant is held.
- burstcount 0 is illegal; treated as 1.
- Response path: on readdatavalid, route the beat to FIFO head id; increment rsp_cnt; when rsp_cnt reaches head burstcount, pop and clear rsp_cnt. readdatavalid with empty FIFO is dropped.
- Push is blocked while full even if a pop happens the same cycle; push and pop together when not full are allowed.

## Timing
- Reset values: all expanded_master_* outputs 0, reqN_waitrequest 1, reqN_readdatavalid 0, reqN_readdata 0, state IDLE, last_grant = 1 (req0 wins first), FIFO empty, counters 0.
- Arbitration bubble: 1 cycle (IDLE) between any two bursts; back-to-back single-beat reads sustain one command per 2 cycles.
- Response latency: readdata/readdatavalid registered, 1 cycle after expanded_master_readdatavalid.
- Reset mid-burst or with reads outstanding: all state cleared; late downstream responses are dropped (FIFO empty).
- Command outputs are combinational from the grant register plus requester inputs; no combinational path from expanded_master_readdatavalid to any output.

## Structure
- Package avmm_arb_pkg: state enum {IDLE, GRANT, WBURST}, tag struct {id: 1 bit, burstcount: BURST_W}, default width constants.
- Sub-module avmm_arb_tag_fifo: synchronous FIFO, PEND_DEPTH entries of tag struct, full/empty flags, registered pointers with an extra wrap bit.
- Top holds FSM, round-robin pointer, beats_left, rsp_cnt, output muxes.

## Test plan
- Both requesters issue single-beat reads at cycle 0 after reset → req0 granted first, then req1; data of each response appears only on the matching reqN_readdatavalid, 1 cycle after downstream.
- req0 write burstcount 4 with waitrequest high on beats 2 and 3 → exactly 4 beats on expanded master, req1 (pending read) held waitrequest=1 until burst completes, then granted.
- 16 outstanding reads of burstcount 2 with no responses → 17th read sees expanded_master_read=0, waitrequest=1; after first 2 response beats, it issues.
- Interleaved reads req0 (bc 3), req1 (bc 1), req0 (bc 2) → response beats split 3/1/2 to 0/1/0 in order.
- Reset asserted during a write burst with 2 reads outstanding → next cycle outputs at reset values; subsequent stray readdatavalid produces no reqN_readdatavalid.
